atm_auth_ctrl: RTL

Parametrised, clocked authentication controller for the ATM design. It holds a writable account/PIN table of `NUM_ACC` entries and scans it sequentially on each login request. It keeps a per-account failed-attempt count with lockout and admin unlock, and owns the user session: activity timeout, logout, and the session account index. The transaction FSM sits downstream and consumes `sess_active`/`sess_idx`.

---
 rtl/atm_auth_ctrl_pkg.sv | 9 +
 rtl/atm_auth_ctrl_if.sv | 28 ++
 rtl/atm_auth_ctrl_fail_tracker.sv | 35 +++
 rtl/atm_auth_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/atm_auth_ctrl_pkg.sv
// atm_pkg: shared FSM states, response codes and fail-count width for the ATM auth controller
package atm_pkg;
  typedef enum logic [2:0] {IDLE, SCAN, CHECK, RESP, SESSION} state_t;
  localparam logic [1:0] RC_OK = 2'd0;
  localparam logic [1:0] RC_BAD_PIN = 2'd1;
  localparam logic [1:0] RC_NO_ACC = 2'd2;
  localparam logic [1:0] RC_LOCKED = 2'd3;
  localparam int FC_W = 3;
endpackage

// File: rtl/atm_auth_ctrl_if.sv
// atm_auth_ctrl_if: config, login, unlock and session signals of the auth controller
interface atm_auth_ctrl_if #(parameter int ACC_W = 12, parameter int PIN_W = 4, parameter int IDX_W = 4);
  logic cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [ACC_W-1:0] cfg_acc;
  logic [PIN_W-1:0] cfg_pin;
  logic req_valid;
  logic req_ready;
  logic [ACC_W-1:0] req_acc;
  logic [PIN_W-1:0] req_pin;
  logic resp_valid;
  logic [1:0] resp_code;
  logic activity;
  logic logout;
  logic unlock;
  logic [IDX_W-1:0] unlock_idx;
  logic sess_active;
  logic [IDX_W-1:0] sess_idx;
  logic sess_timeout;
  modport master (
    output cfg_we, cfg_idx, cfg_acc, cfg_pin, req_valid, req_acc, req_pin, activity, logout, unlock, unlock_idx,
    input req_ready, resp_valid, resp_code, sess_active, sess_idx, sess_timeout
  );
  modport slave (
    input cfg_we, cfg_idx, cfg_acc, cfg_pin, req_valid, req_acc, req_pin, activity, logout, unlock, unlock_idx,
    output req_ready, resp_valid, resp_code, sess_active, sess_idx, sess_timeout
  );
endinterface

// File: rtl/atm_auth_ctrl_fail_tracker.sv
// atm_fail_tracker: per-entry saturating bad-PIN counters and lock bits with admin unlock
module atm_fail_tracker import atm_pkg::*; #(
  parameter int NUM_ACC = 10,
  parameter int IDX_W = 4,
  parameter int MAX_TRIES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  input  logic [IDX_W-1:0] idx,
  input  logic unlock,
  input  logic [IDX_W-1:0] unlock_idx,
  output logic locked
);
  logic [FC_W-1:0] cnt [NUM_ACC];
  logic [NUM_ACC-1:0] lock;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_ACC; i++) cnt[i] <= '0;
      lock <= '0;
    end else
      for (int i = 0; i < NUM_ACC; i++)
        if (unlock && unlock_idx == IDX_W'(i)) begin
          cnt[i] <= '0;
          lock[i] <= 1'b0;
        end else if (idx == IDX_W'(i) && clr) begin
          cnt[i] <= '0;
          lock[i] <= 1'b0;
        end else if (idx == IDX_W'(i) && inc && cnt[i] < FC_W'(MAX_TRIES)) begin
          cnt[i] <= cnt[i] + FC_W'(1);
          lock[i] <= cnt[i] + FC_W'(1) == FC_W'(MAX_TRIES);
        end
  assign locked = lock[idx];
endmodule

// File: rtl/atm_auth_ctrl.sv
// atm_auth_ctrl: sequential account/PIN table scan, lockout and user session ownership
module atm_auth_ctrl import atm_pkg::*; #(
  parameter int NUM_ACC = 10,
  parameter int ACC_W = 12,
  parameter int PIN_W = 4,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT = 1024,
  parameter int IDX_W = $clog2(NUM_ACC)
) (
  input logic clk,
  input logic reset,
  atm_auth_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT);
  state_t state, state_nx;
  logic [IDX_W-1:0] scan_idx, sess_idx_q, trk_idx;
  logic [ACC_W-1:0] lat_acc;
  logic [PIN_W-1:0] lat_pin;
  logic [ACC_W-1:0] tab_acc [NUM_ACC];
  logic [PIN_W-1:0] tab_pin [NUM_ACC];
  logic [NUM_ACC-1:0] tab_vld;
  logic [1:0] rc;
  logic [TW-1:0] timer;
  logic hit, last, pin_ok, locked, cfg_wr, expire;
  assign hit = tab_vld[scan_idx] && tab_acc[scan_idx] == lat_acc;
  assign last = scan_idx == IDX_W'(NUM_ACC-1);
  assign pin_ok = tab_pin[scan_idx] == lat_pin;
  assign cfg_wr = state == IDLE && bus.cfg_we;
  assign expire = state == SESSION && timer == TW'(TIMEOUT-1) && !bus.logout;
  assign trk_idx = state == CHECK ? scan_idx : bus.cfg_idx;
  atm_fail_tracker #(.NUM_ACC(NUM_ACC), .IDX_W(IDX_W), .MAX_TRIES(MAX_TRIES)) u_trk (
    .clk(clk), .reset(reset),
    .inc(state == CHECK && !locked && !pin_ok),
    .clr((state == CHECK && !locked && pin_ok) || cfg_wr),
    .idx(trk_idx), .unlock(bus.unlock), .unlock_idx(bus.unlock_idx), .locked(locked)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.req_valid ? SCAN : IDLE;
      SCAN:    state_nx = hit ? CHECK : last ? RESP : SCAN;
      CHECK:   state_nx = RESP;
      RESP:    state_nx = rc == RC_OK ? SESSION : IDLE;
      SESSION: state_nx = bus.logout || expire ? IDLE : SESSION;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      scan_idx <= '0;
      sess_idx_q <= '0;
      lat_acc <= '0;
      lat_pin <= '0;
      rc <= RC_OK;
      timer <= '0;
      tab_vld <= '0;
      for (int i = 0; i < NUM_ACC; i++) begin
        tab_acc[i] <= '0;
        tab_pin[i] <= '0;
      end
    end else begin
      state <= state_nx;
      timer <= state != SESSION || bus.activity ? '0 : timer + TW'(1);
      if (cfg_wr) begin
        tab_acc[bus.cfg_idx] <= bus.cfg_acc;
        tab_pin[bus.cfg_idx] <= bus.cfg_pin;
        tab_vld[bus.cfg_idx] <= 1'b1;
      end
      if (state == IDLE && bus.req_valid) begin
        lat_acc <= bus.req_acc;
        lat_pin <= bus.req_pin;
        scan_idx <= '0;
      end
      if (state == SCAN && !hit && !last) scan_idx <= scan_idx + IDX_W'(1);
      if (state == SCAN && !hit && last) rc <= RC_NO_ACC;
      if (state == CHECK) rc <= locked ? RC_LOCKED : pin_ok ? RC_OK : RC_BAD_PIN;
      if (state == CHECK && !locked && pin_ok) sess_idx_q <= scan_idx;
    end
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_code = rc;
  assign bus.sess_active = state == SESSION;
  assign bus.sess_idx = sess_idx_q;
  assign bus.sess_timeout = expire;
endmodule
